tc_clk_mux2_seq: RTL and testbench

//  Sequencer that drives the select of a non-glitch-free 2:1 clock mux cell.
//  It runs on an always-on clock and accepts switch requests through a

---
 rtl/tc_clk_mux2_seq.sv | 138 +++++++++++++
 tb/tb_tc_clk_mux2_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_clk_mux2_seq.sv
// Select sequencer for a non-glitch-free 2:1 clock mux.
// For each select change it gates the downstream clock, optionally holds the
// downstream domain in reset, flips the select, waits for the mux output to
// settle, then re-enables the clock.
// Ports:
//   clk_i, rst_i    always-on reference clock, async active-high reset
//   req_valid_i     switch request valid
//   req_sel_i       requested select, sampled on the handshake
//   req_ready_o     high only while IDLE
//   clk_sel_o       registered select to the clock mux
//   clk_gate_en_o   enable for the downstream clock gate
//   dom_rst_o       active-high reset for the downstream domain
//   busy_o          high in any state other than IDLE
//   done_o          one-cycle pulse when a request completes
module tc_clk_mux2_seq #(
  parameter int unsigned GATE_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter bit          HOLD_RST      = 1'b1,
  parameter bit          SEL_RST       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  output logic clk_sel_o,
  output logic clk_gate_en_o,
  output logic dom_rst_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_GATE,
    ST_SETTLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgt_q, tgt_d;
  logic             sel_d, gate_d, drst_d, rdy_d, busy_d, done_d;

  // State, counter and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_INIT;
      cnt_q         <= SETTLE_LOAD;
      tgt_q         <= SEL_RST;
      clk_sel_o     <= SEL_RST;
      clk_gate_en_o <= 1'b0;
      dom_rst_o     <= 1'b1;
      req_ready_o   <= 1'b0;
      busy_o        <= 1'b1;
      done_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tgt_q         <= tgt_d;
      clk_sel_o     <= sel_d;
      clk_gate_en_o <= gate_d;
      dom_rst_o     <= drst_d;
      req_ready_o   <= rdy_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d = state_q;
    // Counter saturates at zero so it can never wrap.
    cnt_d   = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : cnt_q;
    tgt_d   = tgt_q;
    sel_d   = clk_sel_o;
    gate_d  = clk_gate_en_o;
    drst_d  = dom_rst_o;
    rdy_d   = req_ready_o;
    busy_d  = busy_o;
    done_d  = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          gate_d  = 1'b1;
          drst_d  = 1'b0;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (req_valid_i && req_ready_o) begin
          if (req_sel_i == clk_sel_o) begin
            // Already on the requested clock: acknowledge without gating.
            done_d = 1'b1;
          end else begin
            state_d = ST_GATE;
            gate_d  = 1'b0;
            drst_d  = HOLD_RST;
            rdy_d   = 1'b0;
            busy_d  = 1'b1;
            tgt_d   = req_sel_i;
            cnt_d   = GATE_LOAD;
          end
        end
      end
      ST_GATE: begin
        // Select flips only here, with the gate already closed.
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          sel_d   = tgt_q;
          cnt_d   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          gate_d  = 1'b1;
          drst_d  = 1'b0;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_tc_clk_mux2_seq.sv
// Bench for tc_clk_mux2_seq: default instance (4/8, HOLD_RST=1) and a fast
// instance (1/1, HOLD_RST=0), both checked against an elapsed-time model.
module tb_tc_clk_mux2_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v0 = 1'b0, s0 = 1'b0, v1 = 1'b0, s1 = 1'b0;
  logic rdy0, sel0, gate0, dr0, busy0, done0;
  logic rdy1, sel1, gate1, dr1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tc_clk_mux2_seq u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v0), .req_sel_i(s0),
    .req_ready_o(rdy0), .clk_sel_o(sel0), .clk_gate_en_o(gate0),
    .dom_rst_o(dr0), .busy_o(busy0), .done_o(done0)
  );

  tc_clk_mux2_seq #(.GATE_CYCLES(1), .SETTLE_CYCLES(1), .HOLD_RST(1'b0), .SEL_RST(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_sel_i(s1),
    .req_ready_o(rdy1), .clk_sel_o(sel1), .clk_gate_en_o(gate1),
    .dom_rst_o(dr1), .busy_o(busy1), .done_o(done1)
  );

  // Reference model: edges since reset release, and edges since acceptance.
  int   m_init [2];
  int   m_k    [2];   // -1 when idle, else edges elapsed since accept edge
  logic m_sel  [2];
  logic m_tgt  [2];
  logic m_done [2];
  logic m_acc  [2];

  function automatic int g_of(int i);  return (i == 0) ? 4 : 1; endfunction
  function automatic int s_of(int i);  return (i == 0) ? 8 : 1; endfunction
  function automatic logic h_of(int i); return (i == 0) ? 1'b1 : 1'b0; endfunction

  function automatic void model_reset(int i);
    m_init[i] = 0; m_k[i] = -1; m_sel[i] = 1'b0; m_tgt[i] = 1'b0;
    m_done[i] = 1'b0; m_acc[i] = 1'b0;
  endfunction

  function automatic void model_step(int i, logic vld, logic rsel, logic r);
    if (r) begin
      model_reset(i);
      return;
    end
    m_done[i] = 1'b0;
    m_acc[i]  = 1'b0;
    if (m_init[i] < s_of(i)) begin
      m_init[i]++;
    end else if (m_k[i] >= 0) begin
      m_k[i]++;
      if (m_k[i] == g_of(i)) m_sel[i] = m_tgt[i];
      if (m_k[i] == g_of(i) + s_of(i)) begin
        m_k[i] = -1;
        m_done[i] = 1'b1;
      end
    end else if (vld) begin
      m_acc[i] = 1'b1;
      if (rsel == m_sel[i]) m_done[i] = 1'b1;
      else begin
        m_tgt[i] = rsel;
        m_k[i]   = 0;
      end
    end
  endfunction

  // Expected {sel, gate_en, dom_rst, ready, busy, done}
  function automatic logic [5:0] expv(int i);
    if (m_init[i] < s_of(i)) return {m_sel[i], 5'b01010};
    if (m_k[i] >= 0)         return {m_sel[i], 1'b0, h_of(i), 3'b010};
    return {m_sel[i], 4'b1010, m_done[i]};
  endfunction

  function automatic logic [5:0] obs(int i);
    if (i == 0) return {sel0, gate0, dr0, rdy0, busy0, done0};
    return {sel1, gate1, dr1, rdy1, busy1, done1};
  endfunction

  // Advance one edge (model and DUT), leaving time 1 unit after the edge.
  task automatic cyc();
    @(posedge clk);
    model_step(0, v0, s0, rst);
    model_step(1, v1, s1, rst);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset(0); model_reset(1);
    for (int c = 0; c < 5; c++) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) begin
          errors++;
          $display("FAIL reset_hold[%0d] c%0d: got %b want %b", i, c, obs(i), expv(i));
        end
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) begin
          errors++;
          $display("FAIL reset_init[%0d] c%0d: got %b want %b", i, c, obs(i), expv(i));
        end
      end
    end
    checks++;
    if ({gate0, dr0, rdy0, done0} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_idle: got %b want 1010", {gate0, dr0, rdy0, done0});
    end
  endtask

  task automatic test_switch();
    int busy_cnt, done_cnt, dr1_cnt;
    busy_cnt = 0; done_cnt = 0; dr1_cnt = 0;
    v0 = 1'b1; s0 = 1'b1; v1 = 1'b1; s1 = 1'b1;
    cyc();  // E0
    v0 = 1'b0; v1 = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) cyc();
      busy_cnt += int'(busy0);
      done_cnt += int'(done0);
      dr1_cnt  += int'(dr1);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) begin
          errors++;
          $display("FAIL switch[%0d] E0+%0d: got %b want %b", i, c, obs(i), expv(i));
        end
      end
    end
    checks++;
    if (busy_cnt != 12 || done_cnt != 1 || dr1_cnt != 0 || sel0 !== 1'b1) begin
      errors++;
      $display("FAIL switch_totals: busy=%0d done=%0d dr1=%0d sel=%b want 12 1 0 1",
               busy_cnt, done_cnt, dr1_cnt, sel0);
    end
  endtask

  task automatic test_same();
    v0 = 1'b1; s0 = 1'b1;
    cyc();
    v0 = 1'b0;
    checks++;
    if ({sel0, gate0, dr0, rdy0, busy0, done0} !== 6'b110101) begin
      errors++;
      $display("FAIL same_sel_done: got %b want 110101", {sel0, gate0, dr0, rdy0, busy0, done0});
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      checks++;
      if (obs(0) !== expv(0)) begin
        errors++;
        $display("FAIL same_sel c%0d: got %b want %b", c, obs(0), expv(0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones, toggles, first_done, gap;
    logic psel;
    dones = 0; toggles = 0; first_done = 0; gap = 0;
    psel = sel0;
    v0 = 1'b1; s0 = ~sel0;
    for (int c = 0; c < 40 && dones < 2; c++) begin
      cyc();
      checks++;
      if (obs(0) !== expv(0)) begin
        errors++;
        $display("FAIL b2b c%0d: got %b want %b", c, obs(0), expv(0));
      end
      if (sel0 !== psel) toggles++;
      psel = sel0;
      if (done0) begin
        dones++;
        if (dones == 1) begin
          first_done = c;
          s0 = ~s0;
        end else begin
          gap = c - first_done;
          v0 = 1'b0;
        end
      end
    end
    checks++;
    if (dones != 2 || toggles != 2 || gap != 13) begin
      errors++;
      $display("FAIL b2b_totals: dones=%0d toggles=%0d gap=%0d want 2 2 13", dones, toggles, gap);
    end
  endtask

  task automatic test_reset_mid();
    if (sel0 !== 1'b0) begin
      v0 = 1'b1; s0 = 1'b0;
      cyc();
      v0 = 1'b0;
      for (int c = 0; c < 12; c++) cyc();
    end
    v0 = 1'b1; s0 = 1'b1;
    cyc();  // E0
    v0 = 1'b0;
    for (int c = 0; c < 6; c++) cyc();  // E0+6
    checks++;
    if ({sel0, gate0} !== 2'b10) begin
      errors++;
      $display("FAIL mid_pre: sel/gate got %b want 10", {sel0, gate0});
    end
    #2 rst = 1'b1;
    model_reset(0); model_reset(1);
    #1;
    checks++;
    if ({sel0, gate0, dr0, done0, rdy0, busy0} !== 6'b001001) begin
      errors++;
      $display("FAIL mid_async: got %b want 001001", {sel0, gate0, dr0, done0, rdy0, busy0});
    end
    cyc(); cyc();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) begin
          errors++;
          $display("FAIL mid_reinit[%0d] c%0d: got %b want %b", i, c, obs(i), expv(i));
        end
      end
    end
  endtask

  task automatic test_random();
    logic ps0, pg0, ps1, pg1;
    ps0 = sel0; pg0 = gate0; ps1 = sel1; pg1 = gate1;
    for (int c = 0; c < 600; c++) begin
      if (!v0 || m_acc[0]) begin
        v0 = ($urandom_range(0, 3) == 0);
        s0 = 1'($urandom);
      end
      if (!v1 || m_acc[1]) begin
        v1 = ($urandom_range(0, 2) == 0);
        s1 = 1'($urandom);
      end
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) begin
          errors++;
          $display("FAIL random[%0d] c%0d: got %b want %b", i, c, obs(i), expv(i));
        end
      end
      if (sel0 !== ps0) begin
        checks++;
        if (gate0 !== 1'b0 || pg0 !== 1'b0) begin
          errors++;
          $display("FAIL sel0_while_gated c%0d: gate %b->%b want 0->0", c, pg0, gate0);
        end
      end
      if (sel1 !== ps1) begin
        checks++;
        if (gate1 !== 1'b0 || pg1 !== 1'b0) begin
          errors++;
          $display("FAIL sel1_while_gated c%0d: gate %b->%b want 0->0", c, pg1, gate1);
        end
      end
      ps0 = sel0; pg0 = gate0; ps1 = sel1; pg1 = gate1;
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_switch();
    test_same();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
